// File: rtl/e203_lsu_rsp_ctrl.sv
// e203_lsu_rsp_ctrl
// Load/store control stage after the EXU. It passes AGU ICB commands to the
// memory-side ICB and records each accepted command in an in-order tag FIFO.
// The FIFO head describes the memory response currently presented. This block
// routes that response either back to the AGU or to the EXU long-pipe
// writeback, and aligns and extends load data on the writeback path.
//
// Ports:
//   clk, rst               core clock, asynchronous active-high reset
//   agu_icb_cmd_*          command from the AGU (valid/ready, addr, read,
//                          wdata, wmask, size, usign, back2agu, itag)
//   agu_icb_rsp_*          raw response returned to the AGU (valid/ready,
//                          err, rdata)
//   mem_icb_cmd_*          command forwarded to memory (valid/ready, addr,
//                          read, wdata, wmask)
//   mem_icb_rsp_*          response from memory (valid/ready, err, rdata)
//   lsu_o_*                EXU writeback: aligned data, itag, err, ld/st
//                          flags, bad address, bus error
//   lsu_active             FIFO non-empty or an AGU command pending
module e203_lsu_rsp_ctrl #(
  parameter int OUTS_DEPTH = 2,
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int ITAG_W     = 1
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                agu_icb_cmd_valid,
  output logic                agu_icb_cmd_ready,
  input  logic [ADDR_W-1:0]   agu_icb_cmd_addr,
  input  logic                agu_icb_cmd_read,
  input  logic [XLEN-1:0]     agu_icb_cmd_wdata,
  input  logic [XLEN/8-1:0]   agu_icb_cmd_wmask,
  input  logic [1:0]          agu_icb_cmd_size,
  input  logic                agu_icb_cmd_usign,
  input  logic                agu_icb_cmd_back2agu,
  input  logic [ITAG_W-1:0]   agu_icb_cmd_itag,

  output logic                agu_icb_rsp_valid,
  input  logic                agu_icb_rsp_ready,
  output logic                agu_icb_rsp_err,
  output logic [XLEN-1:0]     agu_icb_rsp_rdata,

  output logic                mem_icb_cmd_valid,
  input  logic                mem_icb_cmd_ready,
  output logic [ADDR_W-1:0]   mem_icb_cmd_addr,
  output logic                mem_icb_cmd_read,
  output logic [XLEN-1:0]     mem_icb_cmd_wdata,
  output logic [XLEN/8-1:0]   mem_icb_cmd_wmask,

  input  logic                mem_icb_rsp_valid,
  output logic                mem_icb_rsp_ready,
  input  logic                mem_icb_rsp_err,
  input  logic [XLEN-1:0]     mem_icb_rsp_rdata,

  output logic                lsu_o_valid,
  input  logic                lsu_o_ready,
  output logic [XLEN-1:0]     lsu_o_wbck_wdat,
  output logic [ITAG_W-1:0]   lsu_o_wbck_itag,
  output logic                lsu_o_wbck_err,
  output logic                lsu_o_wbck_ld,
  output logic                lsu_o_wbck_st,
  output logic [ADDR_W-1:0]   lsu_o_cmt_badaddr,
  output logic                lsu_o_cmt_buserr,

  output logic                lsu_active
);

  localparam int PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUTS_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUTS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTS_DEPTH - 1);

  typedef struct packed {
    logic              back2agu;
    logic [ITAG_W-1:0] itag;
    logic              usign;
    logic [1:0]        size;
    logic              read;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  // Pointers wrap modulo OUTS_DEPTH, which also covers a depth of 1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1'b1);
    end
  endfunction

  entry_t           entries_q [OUTS_DEPTH];
  entry_t           entries_d [OUTS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;

  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  entry_t           head_s;
  logic [XLEN-1:0]  shifted_s;
  logic [XLEN-1:0]  ld_data_s;

  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign head_s  = entries_q[rd_ptr_q];

  // Command path. Full comes from a register, so there is no combinational
  // loop between the response pop and the command ready.
  assign mem_icb_cmd_valid = agu_icb_cmd_valid & ~full_q;
  assign agu_icb_cmd_ready = mem_icb_cmd_ready & ~full_q;
  assign mem_icb_cmd_addr  = agu_icb_cmd_addr;
  assign mem_icb_cmd_read  = agu_icb_cmd_read;
  assign mem_icb_cmd_wdata = agu_icb_cmd_wdata;
  assign mem_icb_cmd_wmask = agu_icb_cmd_wmask;

  assign push_s = agu_icb_cmd_valid & agu_icb_cmd_ready;
  assign pop_s  = mem_icb_rsp_valid & mem_icb_rsp_ready;

  // Response routing is selected by the head entry's destination.
  always_comb begin
    agu_icb_rsp_valid = 1'b0;
    lsu_o_valid       = 1'b0;
    mem_icb_rsp_ready = 1'b0;
    if (!empty_s) begin
      if (head_s.back2agu) begin
        agu_icb_rsp_valid = mem_icb_rsp_valid;
        mem_icb_rsp_ready = agu_icb_rsp_ready;
      end else begin
        lsu_o_valid       = mem_icb_rsp_valid;
        mem_icb_rsp_ready = lsu_o_ready;
      end
    end else begin
      mem_icb_rsp_ready = 1'b0;
    end
  end

  // Load data alignment and sign/zero extension for the head entry.
  always_comb begin
    shifted_s = mem_icb_rsp_rdata >> {head_s.addr[1:0], 3'b000};
    case (head_s.size)
      2'd0: begin
        if (head_s.usign) begin
          ld_data_s = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
        end else begin
          ld_data_s = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      2'd1: begin
        if (head_s.usign) begin
          ld_data_s = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
        end else begin
          ld_data_s = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      default: ld_data_s = mem_icb_rsp_rdata;
    endcase
  end

  assign agu_icb_rsp_err   = mem_icb_rsp_err;
  assign agu_icb_rsp_rdata = mem_icb_rsp_rdata;

  // Stores write back zero. The ld/st flags are gated by empty so they never
  // reflect stale entries.
  assign lsu_o_wbck_wdat   = head_s.read ? ld_data_s : {XLEN{1'b0}};
  assign lsu_o_wbck_itag   = head_s.itag;
  assign lsu_o_wbck_err    = mem_icb_rsp_err;
  assign lsu_o_wbck_ld     = ~empty_s & head_s.read;
  assign lsu_o_wbck_st     = ~empty_s & ~head_s.read;
  assign lsu_o_cmt_badaddr = head_s.addr;
  assign lsu_o_cmt_buserr  = mem_icb_rsp_err;

  assign lsu_active = ~empty_s | agu_icb_cmd_valid;

  // Next-state computation for the FIFO storage, pointers, count and full flag.
  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_s) begin
      entries_d[wr_ptr_q] = '{back2agu: agu_icb_cmd_back2agu,
                              itag:     agu_icb_cmd_itag,
                              usign:    agu_icb_cmd_usign,
                              size:     agu_icb_cmd_size,
                              read:     agu_icb_cmd_read,
                              addr:     agu_icb_cmd_addr};
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1'b1);
      2'b01:   count_d = count_q - CNT_W'(1'b1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_C);
  end

  // Entry storage. Contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  // FIFO control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

endmodule

// File: tb/tb_e203_lsu_rsp_ctrl.sv
// Self-checking bench for e203_lsu_rsp_ctrl. Accepted commands push a record
// to a scoreboard queue. Each memory response pops the oldest record, and the
// expected routing and writeback values are derived from that record.
module tb_e203_lsu_rsp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        agu_icb_cmd_valid, agu_icb_cmd_ready;
  logic [31:0] agu_icb_cmd_addr;
  logic        agu_icb_cmd_read;
  logic [31:0] agu_icb_cmd_wdata;
  logic [3:0]  agu_icb_cmd_wmask;
  logic [1:0]  agu_icb_cmd_size;
  logic        agu_icb_cmd_usign, agu_icb_cmd_back2agu;
  logic [0:0]  agu_icb_cmd_itag;
  logic        agu_icb_rsp_valid, agu_icb_rsp_ready, agu_icb_rsp_err;
  logic [31:0] agu_icb_rsp_rdata;
  logic        mem_icb_cmd_valid, mem_icb_cmd_ready;
  logic [31:0] mem_icb_cmd_addr;
  logic        mem_icb_cmd_read;
  logic [31:0] mem_icb_cmd_wdata;
  logic [3:0]  mem_icb_cmd_wmask;
  logic        mem_icb_rsp_valid, mem_icb_rsp_ready, mem_icb_rsp_err;
  logic [31:0] mem_icb_rsp_rdata;
  logic        lsu_o_valid, lsu_o_ready;
  logic [31:0] lsu_o_wbck_wdat;
  logic [0:0]  lsu_o_wbck_itag;
  logic        lsu_o_wbck_err, lsu_o_wbck_ld, lsu_o_wbck_st;
  logic [31:0] lsu_o_cmt_badaddr;
  logic        lsu_o_cmt_buserr, lsu_active;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        b2a;
    logic [0:0]  itag;
    logic        read;
    logic        usign;
    logic [1:0]  size;
    logic [31:0] addr;
  } rec_t;
  rec_t sb[$];

  e203_lsu_rsp_ctrl #(.OUTS_DEPTH(2), .XLEN(32), .ADDR_W(32), .ITAG_W(1)) dut (
    .clk(clk), .rst(rst),
    .agu_icb_cmd_valid(agu_icb_cmd_valid), .agu_icb_cmd_ready(agu_icb_cmd_ready),
    .agu_icb_cmd_addr(agu_icb_cmd_addr), .agu_icb_cmd_read(agu_icb_cmd_read),
    .agu_icb_cmd_wdata(agu_icb_cmd_wdata), .agu_icb_cmd_wmask(agu_icb_cmd_wmask),
    .agu_icb_cmd_size(agu_icb_cmd_size), .agu_icb_cmd_usign(agu_icb_cmd_usign),
    .agu_icb_cmd_back2agu(agu_icb_cmd_back2agu), .agu_icb_cmd_itag(agu_icb_cmd_itag),
    .agu_icb_rsp_valid(agu_icb_rsp_valid), .agu_icb_rsp_ready(agu_icb_rsp_ready),
    .agu_icb_rsp_err(agu_icb_rsp_err), .agu_icb_rsp_rdata(agu_icb_rsp_rdata),
    .mem_icb_cmd_valid(mem_icb_cmd_valid), .mem_icb_cmd_ready(mem_icb_cmd_ready),
    .mem_icb_cmd_addr(mem_icb_cmd_addr), .mem_icb_cmd_read(mem_icb_cmd_read),
    .mem_icb_cmd_wdata(mem_icb_cmd_wdata), .mem_icb_cmd_wmask(mem_icb_cmd_wmask),
    .mem_icb_rsp_valid(mem_icb_rsp_valid), .mem_icb_rsp_ready(mem_icb_rsp_ready),
    .mem_icb_rsp_err(mem_icb_rsp_err), .mem_icb_rsp_rdata(mem_icb_rsp_rdata),
    .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready),
    .lsu_o_wbck_wdat(lsu_o_wbck_wdat), .lsu_o_wbck_itag(lsu_o_wbck_itag),
    .lsu_o_wbck_err(lsu_o_wbck_err), .lsu_o_wbck_ld(lsu_o_wbck_ld),
    .lsu_o_wbck_st(lsu_o_wbck_st), .lsu_o_cmt_badaddr(lsu_o_cmt_badaddr),
    .lsu_o_cmt_buserr(lsu_o_cmt_buserr), .lsu_active(lsu_active)
  );

  always #5 clk = ~clk;

  // A memory response with no outstanding entry leaves both response valids low.
  always @(negedge clk) begin
    if (!rst && mem_icb_rsp_valid) begin
      assert (lsu_o_valid || agu_icb_rsp_valid)
        else $error("protocol violation: memory response with no outstanding entry");
    end
  end

  // Reference load extraction, written in byte-lane terms.
  function automatic logic [31:0] exp_wdat(input rec_t r, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    int          off;
    off = int'(r.addr[1:0]);
    b   = rd[8*off +: 8];
    h   = (off >= 2) ? rd[31:16] : rd[8*off +: 16];
    if (!r.read) return 32'h0000_0000;
    if (r.size == 2'd0) return r.usign ? {24'h000000, b} : {{24{b[7]}}, b};
    if (r.size == 2'd1) return r.usign ? {16'h0000, h} : {{16{h[15]}}, h};
    return rd;
  endfunction

  task automatic issue(input logic [31:0] addr, input logic read, input logic [1:0] size,
                       input logic usign, input logic b2a, input logic [0:0] itag);
    int   cyc;
    rec_t r;
    agu_icb_cmd_valid    = 1'b1;
    agu_icb_cmd_addr     = addr;
    agu_icb_cmd_read     = read;
    agu_icb_cmd_size     = size;
    agu_icb_cmd_usign    = usign;
    agu_icb_cmd_back2agu = b2a;
    agu_icb_cmd_itag     = itag;
    agu_icb_cmd_wdata    = 32'hA5A5_0000 ^ addr;
    agu_icb_cmd_wmask    = 4'hF;
    cyc = 0;
    @(negedge clk);
    while (!agu_icb_cmd_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (agu_icb_cmd_ready !== 1'b1) begin
      $display("FAIL issue_timeout addr=%h: agu_icb_cmd_ready=%b required 1", addr, agu_icb_cmd_ready);
    end else begin
      n_pass++;
    end
    n_total++;
    if ({mem_icb_cmd_valid, mem_icb_cmd_addr, mem_icb_cmd_read, mem_icb_cmd_wdata, mem_icb_cmd_wmask}
        !== {1'b1, addr, read, 32'hA5A5_0000 ^ addr, 4'hF}) begin
      $display("FAIL cmd_passthru: got v=%b a=%h r=%b w=%h m=%h required v=1 a=%h r=%b w=%h m=f",
               mem_icb_cmd_valid, mem_icb_cmd_addr, mem_icb_cmd_read, mem_icb_cmd_wdata,
               mem_icb_cmd_wmask, addr, read, 32'hA5A5_0000 ^ addr);
    end else begin
      n_pass++;
    end
    r = '{b2a: b2a, itag: itag, read: read, usign: usign, size: size, addr: addr};
    if (agu_icb_cmd_ready) sb.push_back(r);
    @(posedge clk);
    #1;
    agu_icb_cmd_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata, input logic err, input int stall);
    rec_t        r;
    logic [31:0] ew;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL respond_no_record: scoreboard empty, required an outstanding record");
      return;
    end
    r  = sb.pop_front();
    ew = exp_wdat(r, rdata);
    mem_icb_rsp_valid = 1'b1;
    mem_icb_rsp_rdata = rdata;
    mem_icb_rsp_err   = err;
    // While stalled, only the non-selected side is ready.
    agu_icb_rsp_ready = ~r.b2a;
    lsu_o_ready       = r.b2a;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      n_total++;
      if ({mem_icb_rsp_ready, agu_icb_rsp_valid, lsu_o_valid, lsu_active} !== {1'b0, r.b2a, ~r.b2a, 1'b1}) begin
        $display("FAIL rsp_stall: rdy/agu_v/lsu_v/active=%b%b%b%b required 0%b%b1",
                 mem_icb_rsp_ready, agu_icb_rsp_valid, lsu_o_valid, lsu_active, r.b2a, ~r.b2a);
      end else begin
        n_pass++;
      end
      @(posedge clk);
      #1;
    end
    agu_icb_rsp_ready = r.b2a;
    lsu_o_ready       = ~r.b2a;
    @(negedge clk);
    n_total++;
    if (r.b2a) begin
      if ({agu_icb_rsp_valid, lsu_o_valid, agu_icb_rsp_err, agu_icb_rsp_rdata, mem_icb_rsp_ready}
          !== {1'b1, 1'b0, err, rdata, 1'b1}) begin
        $display("FAIL agu_rsp: v=%b lsu_v=%b err=%b rdata=%h rdy=%b required 1 0 %b %h 1",
                 agu_icb_rsp_valid, lsu_o_valid, agu_icb_rsp_err, agu_icb_rsp_rdata,
                 mem_icb_rsp_ready, err, rdata);
      end else begin
        n_pass++;
      end
    end else begin
      if ({lsu_o_valid, agu_icb_rsp_valid, mem_icb_rsp_ready} !== 3'b101) begin
        $display("FAIL lsu_route: lsu_v=%b agu_v=%b rdy=%b required 1 0 1",
                 lsu_o_valid, agu_icb_rsp_valid, mem_icb_rsp_ready);
      end else begin
        n_pass++;
      end
      n_total++;
      if (lsu_o_wbck_wdat !== ew) begin
        $display("FAIL wbck_wdat addr=%h: got %h required %h", r.addr, lsu_o_wbck_wdat, ew);
      end else begin
        n_pass++;
      end
      n_total++;
      if ({lsu_o_wbck_itag, lsu_o_wbck_ld, lsu_o_wbck_st, lsu_o_wbck_err, lsu_o_cmt_buserr, lsu_o_cmt_badaddr}
          !== {r.itag, r.read, ~r.read, err, err, r.addr}) begin
        $display("FAIL wbck_info: itag=%b ld=%b st=%b err=%b buserr=%b badaddr=%h required %b %b %b %b %b %h",
                 lsu_o_wbck_itag, lsu_o_wbck_ld, lsu_o_wbck_st, lsu_o_wbck_err, lsu_o_cmt_buserr,
                 lsu_o_cmt_badaddr, r.itag, r.read, ~r.read, err, err, r.addr);
      end else begin
        n_pass++;
      end
    end
    @(posedge clk);
    #1;
    mem_icb_rsp_valid = 1'b0;
    mem_icb_rsp_err   = 1'b0;
    agu_icb_rsp_ready = 1'b0;
    lsu_o_ready       = 1'b0;
  endtask

  task automatic expect_empty(input string tag);
    agu_icb_rsp_ready = 1'b1;
    lsu_o_ready       = 1'b1;
    @(negedge clk);
    n_total++;
    if ({lsu_active, mem_icb_rsp_ready, agu_icb_cmd_ready} !== 3'b001) begin
      $display("FAIL %s_empty: active/rsp_rdy/cmd_rdy=%b%b%b required 001",
               tag, lsu_active, mem_icb_rsp_ready, agu_icb_cmd_ready);
    end else begin
      n_pass++;
    end
    @(posedge clk);
    #1;
    agu_icb_rsp_ready = 1'b0;
    lsu_o_ready       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_total++;
    if ({agu_icb_cmd_ready, mem_icb_cmd_valid, agu_icb_rsp_valid, lsu_o_valid, lsu_active} !== 5'b10000) begin
      $display("FAIL reset_state: rdy/mcv/agv/lsv/act=%b%b%b%b%b required 10000",
               agu_icb_cmd_ready, mem_icb_cmd_valid, agu_icb_rsp_valid, lsu_o_valid, lsu_active);
    end else begin
      n_pass++;
    end
    mem_icb_cmd_ready = 1'b0;
    agu_icb_cmd_valid = 1'b1;
    #1;
    n_total++;
    if ({agu_icb_cmd_ready, mem_icb_cmd_valid, lsu_active} !== 3'b011) begin
      $display("FAIL reset_follow: rdy/mcv/act=%b%b%b required 011",
               agu_icb_cmd_ready, mem_icb_cmd_valid, lsu_active);
    end else begin
      n_pass++;
    end
    agu_icb_cmd_valid = 1'b0;
    mem_icb_cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_word_load();
    issue(32'h0000_0100, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    respond(32'hDEAD_BEEF, 1'b0, 0);
    expect_empty("word_load");
  endtask

  task automatic test_byte_half_load();
    issue(32'h0000_0103, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    respond(32'h8012_3456, 1'b0, 0);
    issue(32'h0000_0103, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    respond(32'h8012_3456, 1'b0, 0);
    issue(32'h0000_0102, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    respond(32'h7FFF_1234, 1'b0, 0);
    issue(32'h0000_0101, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    respond(32'h12C3_4500, 1'b0, 0);
    expect_empty("byte_half");
  endtask

  task automatic test_back_to_back();
    rec_t r;
    issue(32'h0000_0200, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    issue(32'h0000_0204, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    agu_icb_cmd_valid    = 1'b1;
    agu_icb_cmd_addr     = 32'h0000_0208;
    agu_icb_cmd_read     = 1'b1;
    agu_icb_cmd_size     = 2'd2;
    agu_icb_cmd_usign    = 1'b0;
    agu_icb_cmd_back2agu = 1'b0;
    agu_icb_cmd_itag     = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_total++;
      if ({agu_icb_cmd_ready, mem_icb_cmd_valid} !== 2'b00) begin
        $display("FAIL full_stall: rdy/mcv=%b%b required 00", agu_icb_cmd_ready, mem_icb_cmd_valid);
      end else begin
        n_pass++;
      end
      @(posedge clk);
      #1;
    end
    respond(32'h1111_1111, 1'b0, 0);
    @(negedge clk);
    n_total++;
    if (agu_icb_cmd_ready !== 1'b1) begin
      $display("FAIL accept_after_pop: agu_icb_cmd_ready=%b required 1", agu_icb_cmd_ready);
    end else begin
      n_pass++;
    end
    r = '{b2a: 1'b0, itag: 1'b0, read: 1'b1, usign: 1'b0, size: 2'd2, addr: 32'h0000_0208};
    if (agu_icb_cmd_ready) sb.push_back(r);
    @(posedge clk);
    #1;
    agu_icb_cmd_valid = 1'b0;
    respond(32'h2222_2222, 1'b0, 0);
    respond(32'h3333_3333, 1'b0, 0);
    expect_empty("back_to_back");
  endtask

  task automatic test_back2agu_err();
    issue(32'h0000_0040, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0);
    respond(32'hCAFE_0001, 1'b1, 2);
    expect_empty("back2agu");
  endtask

  task automatic test_store_err_reset();
    issue(32'h0000_2004, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1);
    respond(32'h0BAD_F00D, 1'b1, 1);
    issue(32'h0000_3000, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    issue(32'h0000_3004, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    n_total++;
    if ({lsu_active, agu_icb_cmd_ready, lsu_o_valid, agu_icb_rsp_valid} !== 4'b0100) begin
      $display("FAIL reset_midflight: act/rdy/lsv/agv=%b%b%b%b required 0100",
               lsu_active, agu_icb_cmd_ready, lsu_o_valid, agu_icb_rsp_valid);
    end else begin
      n_pass++;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    // Two fresh commands must both be accepted if the count was cleared.
    issue(32'h0000_4001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    issue(32'h0000_4002, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    respond(32'h00AB_CD00, 1'b0, 0);
    respond(32'hFEDC_0000, 1'b0, 0);
    expect_empty("after_reset");
  endtask

  initial begin
    rst = 1'b1;
    agu_icb_cmd_valid = 1'b0; agu_icb_cmd_addr = 32'h0; agu_icb_cmd_read = 1'b0;
    agu_icb_cmd_wdata = 32'h0; agu_icb_cmd_wmask = 4'h0; agu_icb_cmd_size = 2'd0;
    agu_icb_cmd_usign = 1'b0; agu_icb_cmd_back2agu = 1'b0; agu_icb_cmd_itag = 1'b0;
    agu_icb_rsp_ready = 1'b0; mem_icb_cmd_ready = 1'b1;
    mem_icb_rsp_valid = 1'b0; mem_icb_rsp_err = 1'b0; mem_icb_rsp_rdata = 32'h0;
    lsu_o_ready = 1'b0;
    test_reset();
    test_word_load();
    test_byte_half_load();
    test_back_to_back();
    test_back2agu_err();
    test_store_err_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
